sseg_display_arbiter: RTL and testbench
=======================================

# sseg_display_arbiter

Shares the 4-digit seven-segment display between a software (MMIO) value source and a motion-alert source, and drives the display by time-multiplexing the digits with hex decoding. It sits between the bus-side register file or motion logic and the board `seg`/`an` pins. It replaces single-digit static driving with full 4-digit scanning, priority arbitration and tear-free software updates.

## Interface
- `REFRESH_DIV`, default 100_000: clock cycles per digit slot (1 kHz per digit at 100 MHz); minimum 2.
- `HOLD_CYCLES`, default 50_000_000: cycles the alert keeps ownership after `alert_req` falls; minimum 1.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `sw_valid`  in  1  software write request.
- `sw_value`  in  16  software value, 4 hex nibbles; nibble 0 drives the rightmost digit.
- `sw_blank`  in  4  per-digit blank mask, captured with `sw_value`; bit i blanks digit i.
- `sw_ready`  out  1  write accepted when `sw_valid && sw_ready`.
- `alert_req`  in  1  level request from the motion logic.
- `alert_value`  in  16  value shown while the alert owns the display.
- `owner`  out  1  0 = software owns the display, 1 = alert owns it (ALERT or HOLD).
- `digit_tick`  out  1  one-cycle pulse on every digit-index advance.
- `seg`  out  7  active-low segments, bit order gfedcba.
- `an`  out  4  active-low digit enables.

## Operation
- Reset values:
  - Outputs: `an`=4'b1111, `seg`=7'b1111111, `sw_ready`=1, `owner`=0, `digit_tick`=0.
  - Internal: FSM=SW, digit index=0, refresh counter=0, pending=0, committed value/mask=0, alert latch=0, hold counter=0.
- Arbiter FSM, registered:
  - SW → ALERT when `alert_req`=1.
  - ALERT: latches `alert_value` every cycle. When `alert_req`=0, goes to HOLD and loads hold counter with HOLD_CYCLES-1.
  - HOLD: displays the alert latch.
    - `alert_req`=1 → ALERT; the hold counter is discarded.
    - Otherwise, counter=0 → SW; else the counter decrements.
- Source switching takes effect mid-frame; the FSM does not wait for a frame boundary.
- Software path:
  - `sw_ready` = NOT pending.
  - On accept, `sw_value`/`sw_blank` are captured into the pending register and pending is set to 1.
  - At the frame boundary (the `digit_tick` where index wraps 3→0), pending is copied to committed and pending is cleared.
  - An accept and a frame boundary in the same cycle cannot collide, because `sw_ready`=0 whenever a pending write exists. A write accepted on the boundary cycle commits at the next boundary.
  - Writes are accepted and committed in every FSM state. A committed value becomes visible on return to SW.
- Scanner:
  - The refresh counter counts 0..REFRESH_DIV-1.
  - At the terminal count it wraps to 0, the index advances mod 4, and `digit_tick` pulses.
- Output register:
  - Updated every cycle from the current index and the selected source.
  - Index i drives `an` = all ones except bit i low, and `seg` = decode(nibble i).
  - Blanked digit (committed mask bit set, SW source only): `an`=4'b1111, `seg`=7'b1111111.
  - The alert source is never blanked.
- Decode table, 0–F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- Reset mid-operation returns everything to the reset values on the next edge. Any pending write is lost.

## Timing
- `owner` rises 1 cycle after `alert_req` rises; `seg`/`an` show the alert source 2 cycles after it rises.
- On the first edge after `rst` deasserts, the outputs show index 0 of the committed value (`an`=4'b1110, `seg`=1000000).
- The first `digit_tick` occurs REFRESH_DIV cycles after reset release. Each digit is shown for exactly REFRESH_DIV cycles; a frame is 4·REFRESH_DIV cycles.
- `an` changes 1 cycle after `digit_tick`.
- `alert_req` falling to `owner`=0 takes HOLD_CYCLES+1 cycles: 1 cycle ALERT→HOLD, then HOLD_CYCLES cycles in HOLD.
- A committed value appears on the display at the first output update after the frame boundary, i.e. with digit 0.
- `sw_ready` falls on the edge of the accept and rises on the frame-boundary edge.

## Test plan
Bench parameters: REFRESH_DIV=4, HOLD_CYCLES=10.
- Reset release, no writes → `an` sequences 1110, 1101, 1011, 0111 every 4 cycles, `seg`=1000000 throughout, `digit_tick` every 4 cycles.
- Write 16'h12AF mask 0 → `sw_ready`=0 until the next wrap. The next frame shows digit 0 = 0001110 (F), digit 1 = 0001000 (A), digit 2 = 0100100 (2), digit 3 = 1111001 (1).
- Write 16'h0008 mask 4'b1100 → digits 2 and 3 give `an`=1111 and `seg`=1111111; digit 0 shows 0000000.
- `alert_req` pulsed high for 3 cycles with `alert_value`=16'h00E1 → `owner`=1 at +1 cycle, digit 0 shows 1111001 at +2. After the fall, `owner` returns to 0 exactly 11 cycles later and the display reverts to the committed SW value.
- `alert_req` re-asserted in HOLD with 5 cycles left → FSM back to ALERT, `owner` stays 1, and a full 10-cycle hold restarts after the next fall.
- `rst` asserted mid-frame with a pending write → `an`=1111, `sw_ready`=1 next edge; after release, committed value is 0.

Source files
------------

// File: rtl/sseg_display_arbiter.sv
// sseg_display_arbiter
//
// Shares a 4-digit, common-anode seven-segment display between a software
// (MMIO) value source and a motion-alert source. The digits are scanned one
// at a time (REFRESH_DIV clocks per digit) and each nibble is hex-decoded.
//
// Arbitration:
//   SW    : software owns the display.
//   ALERT : alert owns the display. alert_value is latched every cycle.
//   HOLD  : the alert keeps ownership for HOLD_CYCLES after alert_req falls.
//           A new alert_req returns to ALERT and discards the countdown.
//
// Software writes are double-buffered. An accepted write lands in a pending
// register and is copied to the committed register at the frame boundary,
// which is the 3->0 index wrap. A frame therefore never shows a mix of old
// and new digits.
//
// Parameters:
//   REFRESH_DIV  clocks per digit slot (>= 2)
//   HOLD_CYCLES  clocks of alert ownership after alert_req falls (>= 1)
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   sw_valid     software write request
//   sw_value     16-bit value; nibble 0 drives the rightmost digit
//   sw_blank     per-digit blank mask, captured with sw_value
//   sw_ready     write accepted when sw_valid && sw_ready
//   alert_req    level request from the motion logic
//   alert_value  value shown while the alert owns the display
//   owner        0 = software, 1 = alert (ALERT or HOLD)
//   digit_tick   one-cycle pulse on every digit-index advance
//   seg          active-low segments, bit order gfedcba
//   an           active-low digit enables
module sseg_display_arbiter #(
  parameter int unsigned REFRESH_DIV = 100_000,
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sw_valid,
  input  logic [15:0] sw_value,
  input  logic [3:0]  sw_blank,
  output logic        sw_ready,
  input  logic        alert_req,
  input  logic [15:0] alert_value,
  output logic        owner,
  output logic        digit_tick,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int unsigned RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD    = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SW    = 2'd0,
    ST_ALERT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Hex digit to active-low gfedcba segment pattern.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1111000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b0000011;
      4'hC:    pat = 7'b1000110;
      4'hD:    pat = 7'b0100001;
      4'hE:    pat = 7'b0000110;
      default: pat = 7'b0001110;
    endcase
    return pat;
  endfunction

  // Scanner state
  logic [RW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic          slot_end;
  logic          frame_wrap;

  // Software path state
  logic          pending;
  logic [15:0]   pend_value;
  logic [3:0]    pend_blank;
  logic [15:0]   commit_value;
  logic [3:0]    commit_blank;
  logic          sw_accept;

  // Arbiter state
  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [15:0]   alert_latch;

  // Output pipeline
  logic [15:0]   src_value_p0;
  logic [3:0]    nibble_p0;
  logic          blank_p0;
  logic [3:0]    an_p0;
  logic [6:0]    seg_p1;
  logic [3:0]    an_p1;

  assign slot_end   = (refresh_cnt == REFRESH_LAST);
  assign frame_wrap = slot_end && (digit_idx == 2'd3);

  // The pending flag is the only backpressure. Because sw_ready is low while
  // a write is pending, an accept can never coincide with a commit.
  assign sw_ready  = ~pending;
  assign sw_accept = sw_valid && ~pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
      digit_tick  <= 1'b0;
    end else if (slot_end) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
      digit_tick  <= 1'b1;
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
      digit_tick  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending      <= 1'b0;
      pend_value   <= '0;
      pend_blank   <= '0;
      commit_value <= '0;
      commit_blank <= '0;
    end else if (sw_accept) begin
      pending    <= 1'b1;
      pend_value <= sw_value;
      pend_blank <= sw_blank;
    end else if (pending && frame_wrap) begin
      pending      <= 1'b0;
      commit_value <= pend_value;
      commit_blank <= pend_blank;
    end
  end

  // The latch also loads on the SW->ALERT edge. As a result, the alert value
  // is already in place when the output stage first selects the alert source.
  always_ff @(posedge clk) begin
    if (rst) begin
      alert_latch <= '0;
    end else if (alert_req || (state == ST_ALERT)) begin
      alert_latch <= alert_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_SW;
      hold_cnt <= '0;
      owner    <= 1'b0;
    end else begin
      case (state)
        ST_SW: begin
          if (alert_req) begin
            state <= ST_ALERT;
            owner <= 1'b1;
          end
        end
        ST_ALERT: begin
          owner <= 1'b1;
          if (!alert_req) begin
            state    <= ST_HOLD;
            hold_cnt <= HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          if (alert_req) begin
            state <= ST_ALERT;
            owner <= 1'b1;
          end else if (hold_cnt == '0) begin
            state <= ST_SW;
            owner <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        default: begin
          state <= ST_SW;
          owner <= 1'b0;
        end
      endcase
    end
  end

  // ---- p0: source select, nibble pick, blank decision ----
  always_comb begin
    src_value_p0 = (state == ST_SW) ? commit_value : alert_latch;
    blank_p0     = (state == ST_SW) && commit_blank[digit_idx];
    nibble_p0    = src_value_p0[{digit_idx, 2'b00} +: 4];
    an_p0        = ~(4'b0001 << digit_idx);
  end

  // ---- p1: registered pin drive ----
  always_ff @(posedge clk) begin
    if (rst) begin
      an_p1  <= 4'b1111;
      seg_p1 <= 7'b1111111;
    end else if (blank_p0) begin
      an_p1  <= 4'b1111;
      seg_p1 <= 7'b1111111;
    end else begin
      an_p1  <= an_p0;
      seg_p1 <= hex_decode(nibble_p0);
    end
  end

  assign an  = an_p1;
  assign seg = seg_p1;

endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Testbench for sseg_display_arbiter. A reference model tracks, at every
// clock edge, what the pins must show. It works from the elapsed edge count
// since reset and from the time of the most recent alert request, and pushes
// that expectation into a queue. A monitor on the falling edge pops one entry
// per cycle and compares it with the DUT pins.
module tb_sseg_display_arbiter;

  localparam int DIV  = 4;
  localparam int HOLD = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        sw_valid;
  logic [15:0] sw_value;
  logic [3:0]  sw_blank;
  logic        sw_ready;
  logic        alert_req;
  logic [15:0] alert_value;
  logic        owner;
  logic        digit_tick;
  logic [6:0]  seg;
  logic [3:0]  an;

  sseg_display_arbiter #(
    .REFRESH_DIV(DIV),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_valid(sw_valid),
    .sw_value(sw_value),
    .sw_blank(sw_blank),
    .sw_ready(sw_ready),
    .alert_req(alert_req),
    .alert_value(alert_value),
    .owner(owner),
    .digit_tick(digit_tick),
    .seg(seg),
    .an(an)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       ready;
    logic       owner;
    logic       tick;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] dec_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model state
  int          m_n;
  bit          m_have_req;
  int          m_last_req;
  bit          m_owner;
  bit          m_pending;
  logic [15:0] m_pend_val, m_com_val, m_latch;
  logic [3:0]  m_pend_blk, m_com_blk;

  always @(posedge clk) begin
    obs_t        e;
    int          idx;
    logic [15:0] val;
    if (rst) begin
      m_n        = 0;
      m_have_req = 0;
      m_last_req = 0;
      m_owner    = 0;
      m_pending  = 0;
      m_com_val  = '0;
      m_com_blk  = '0;
      m_latch    = '0;
      e = '{an: 4'b1111, seg: 7'b1111111, ready: 1'b1, owner: 1'b0, tick: 1'b0};
    end else begin
      m_n = m_n + 1;
      idx = ((m_n - 1) / DIV) % 4;
      // The display reflects ownership and committed data from before this edge.
      if (!m_owner && m_com_blk[idx]) begin
        e.an  = 4'b1111;
        e.seg = 7'b1111111;
      end else begin
        val   = m_owner ? m_latch : m_com_val;
        e.an  = 4'b1111;
        e.an[idx] = 1'b0;
        e.seg = dec_tab[val[idx*4 +: 4]];
      end
      e.tick = ((m_n % DIV) == 0);
      if (m_pending && ((m_n % (4 * DIV)) == 0)) begin
        m_com_val = m_pend_val;
        m_com_blk = m_pend_blk;
        m_pending = 0;
      end else if (!m_pending && sw_valid) begin
        m_pending  = 1;
        m_pend_val = sw_value;
        m_pend_blk = sw_blank;
      end
      if (alert_req) begin
        m_have_req = 1;
        m_last_req = m_n;
        m_latch    = alert_value;
      end
      // Alert owns the display until HOLD+1 edges after its last request.
      m_owner = m_have_req && ((m_n - m_last_req) <= HOLD);
      e.owner = m_owner;
      e.ready = !m_pending;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{an: an, seg: seg, ready: sw_ready, owner: owner, tick: digit_tick};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL pins t=%0t an got %b exp %b | seg got %b exp %b | ready got %b exp %b | owner got %b exp %b | tick got %b exp %b",
                 $time, a.an, e.an, a.seg, e.seg, a.ready, e.ready, a.owner, e.owner, a.tick, e.tick);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sw_write(input logic [15:0] v, input logic [3:0] b);
    sw_valid = 1'b1;
    sw_value = v;
    sw_blank = b;
    cyc(1);
    sw_valid = 1'b0;
  endtask

  task automatic alert_pulse(input logic [15:0] v, input int len);
    alert_req   = 1'b1;
    alert_value = v;
    cyc(len);
    alert_req   = 1'b0;
  endtask

  initial begin
    bit cur_req;
    rst         = 1'b1;
    sw_valid    = 1'b0;
    sw_value    = '0;
    sw_blank    = '0;
    alert_req   = 1'b0;
    alert_value = '0;
    cyc(3);
    rst = 1'b0;

    // Idle scan after reset
    cyc(20);
    // Plain write, then a partially blanked write
    sw_write(16'h12AF, 4'b0000);
    cyc(35);
    sw_write(16'h0008, 4'b1100);
    cyc(35);
    // Short alert pulse, then full hold and revert
    alert_pulse(16'h00E1, 3);
    cyc(20);
    // Re-assert in HOLD with 5 cycles left
    alert_pulse(16'hBEEF, 2);
    cyc(5);
    alert_pulse(16'hBEEF, 2);
    cyc(20);
    // Write accepted and committed while the alert owns the display
    alert_req   = 1'b1;
    alert_value = 16'h7C3D;
    cyc(2);
    sw_write(16'h4567, 4'b0001);
    cyc(20);
    alert_req = 1'b0;
    cyc(20);

    // Randomized phase
    cur_req = 1'b0;
    for (int i = 0; i < 800; i++) begin
      sw_valid = ($urandom_range(3) == 0);
      sw_value = 16'($urandom);
      sw_blank = 4'($urandom);
      if (!cur_req && $urandom_range(19) == 0) begin
        cur_req     = 1'b1;
        alert_value = 16'($urandom);
      end else if (cur_req && $urandom_range(3) == 0) begin
        cur_req = 1'b0;
      end
      alert_req = cur_req;
      cyc(1);
    end
    sw_valid  = 1'b0;
    alert_req = 1'b0;
    cyc(30);

    // Reset mid-frame with a pending write
    cyc(2);
    sw_write(16'h9999, 4'b0000);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(40);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain queue size got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
